// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
// Group width, group count helper and add/subtract opcode encodings.
package cla_pkg;

  localparam int GROUP_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int ngrp(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_cla4_group.sv
// 4-bit carry-lookahead group: per-bit propagate, group generate/propagate,
// and the group sum for a given carry-in (all carries flat, no ripple).
module cla4_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] p,
  output logic       gg,
  output logic       gp,
  output logic [3:0] sum
);

  logic [3:0] g;
  logic [3:1] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

  assign sum = p ^ {c[3], c[2], c[1], c_in};

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Optional build macro ADD_SAT_EN adds a 'sat' input that clamps signed overflow.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] bi,
  input  logic             C0,
  input  logic             sub,
`ifdef ADD_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = ngrp(WIDTH);

  logic             out_adv, s1_adv, accept;

  logic [WIDTH-1:0] b_d, p_d;
  logic             cin_d;
  logic [NGRP-1:0]  gg_d, gp_d;

  logic [WIDTH-1:0] a_q, b_q, p_q;
  logic             cin_q, s1_v_q;
  logic [NGRP-1:0]  gg_q, gp_q;
`ifdef ADD_SAT_EN
  logic             sat_q;
`endif

  logic [NGRP:0]    grp_c;
  logic [WIDTH-1:0] raw_s, s_d;
  logic             co_d, ovf_d, zero_d, c_msb_in;

  logic [WIDTH-1:0] s_q;
  logic             co_q, ovf_q, zero_q, out_valid_q;

  // in_ready depends only on registered state and out_ready.
  assign out_adv  = ~out_valid_q | out_ready;
  assign s1_adv   = s1_v_q & out_adv;
  assign in_ready = ~s1_v_q | out_adv;
  assign accept   = in_valid & in_ready;

  assign b_d   = bi ^ {WIDTH{sub == OP_SUB}};
  assign cin_d = (sub == OP_SUB) ? 1'b1 : C0;

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_s1
      logic [3:0] s1_sum_unused;
      cla4_group u_grp (
        .a    (ai[gi*GROUP_W +: GROUP_W]),
        .b    (b_d[gi*GROUP_W +: GROUP_W]),
        .c_in (1'b0),
        .p    (p_d[gi*GROUP_W +: GROUP_W]),
        .gg   (gg_d[gi]),
        .gp   (gp_d[gi]),
        .sum  (s1_sum_unused)
      );
    end
  endgenerate

  // Second-level lookahead: every group carry is a flat sum of products.
  always_comb begin
    logic acc;
    logic term;
    acc      = 1'b0;
    term     = 1'b0;
    grp_c    = '0;
    grp_c[0] = cin_q;
    for (int k = 0; k < NGRP; k++) begin
      acc = cin_q;
      for (int j = 0; j <= k; j++) acc = acc & gp_q[j];
      for (int j = 0; j <= k; j++) begin
        term = gg_q[j];
        for (int m = j + 1; m <= k; m++) term = term & gp_q[m];
        acc = acc | term;
      end
      grp_c[k+1] = acc;
    end
  end

  generate
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2
      logic [3:0] s2_p, s2_sum;
      logic       s2_gg_unused, s2_gp_unused;
      cla4_group u_grp (
        .a    (a_q[gi*GROUP_W +: GROUP_W]),
        .b    (b_q[gi*GROUP_W +: GROUP_W]),
        .c_in (grp_c[gi]),
        .p    (s2_p),
        .gg   (s2_gg_unused),
        .gp   (s2_gp_unused),
        .sum  (s2_sum)
      );
      // s2_sum ^ s2_p recovers the local carries of this group.
      assign raw_s[gi*GROUP_W +: GROUP_W] = p_q[gi*GROUP_W +: GROUP_W] ^ (s2_sum ^ s2_p);
    end
  endgenerate

  assign co_d     = grp_c[NGRP];
  assign c_msb_in = p_q[WIDTH-1] ^ raw_s[WIDTH-1];
  assign ovf_d    = c_msb_in ^ co_d;

`ifdef ADD_SAT_EN
  // Wrapped MSB set means positive overflow, so clamp to the opposite extreme.
  assign s_d = (sat_q && ovf_d) ? {~raw_s[WIDTH-1], {(WIDTH-1){raw_s[WIDTH-1]}}} : raw_s;
`else
  assign s_d = raw_s;
`endif

  assign zero_d = ~|s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      cin_q       <= 1'b0;
      gg_q        <= '0;
      gp_q        <= '0;
      s1_v_q      <= 1'b0;
`ifdef ADD_SAT_EN
      sat_q       <= 1'b0;
`endif
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= ai;
        b_q    <= b_d;
        p_q    <= p_d;
        cin_q  <= cin_d;
        gg_q   <= gg_d;
        gp_q   <= gp_d;
        s1_v_q <= 1'b1;
`ifdef ADD_SAT_EN
        sat_q  <= sat;
`endif
      end else if (s1_adv) begin
        s1_v_q <= 1'b0;
      end

      if (out_adv) begin
        out_valid_q <= s1_v_q;
        if (s1_v_q) begin
          s_q    <= s_d;
          co_q   <= co_d;
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
